id_ex_operand_latch: RTL and testbench

Pipeline stage between decode and execute. Each cycle it may capture an instruction word together with its two register-file read values. It forms ALU operand B from either a register value or the 16-bit immediate (sign-extended, zero-extended, or upper-placed). The result is held in a two-entry skid buffer with valid/ready handshakes on both sides, so back-pressure from execute never produces a combinational path to decode.

---
 rtl/id_ex_operand_latch.sv | 151 +++++++++++++++
 tb/tb_id_ex_operand_latch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_latch.sv
// id_ex_operand_latch
//
// Pipeline register between decode and execute. Each accepted instruction
// has its ALU operand B resolved up front (register value or one of three
// immediate forms) and is stored with its other operands. Storage is a
// two-entry skid buffer, so a stall from execute reaches decode only
// through a register.
//
// Ports (all buses MSB-first, bit 0 = MSB):
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    upstream presents an instruction
//   in_ready    stage can accept (registered)
//   instr       opcode[0:5] rs[6:10] rt[11:15] rd[16:20] imm[16:31]
//   rs_data     register-file read A
//   rt_data     register-file read B
//   b_sel       00 rt_data, 01 sign-ext imm, 10 zero-ext imm, 11 imm<<16
//   flush       discard all held and incoming entries
//   out_valid   head entry available to execute
//   out_ready   execute accepts the head entry
//   op_a        rs_data of the head entry
//   op_b        resolved operand B of the head entry
//   store_data  rt_data of the head entry, unaltered
//   dest_reg    rt for immediate forms, rd for register form
//   opcode      opcode of the head entry

module id_ex_operand_latch #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:31]       instr,
    input  logic [0:DATA_W-1] rs_data,
    input  logic [0:DATA_W-1] rt_data,
    input  logic [0:1]        b_sel,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:DATA_W-1] op_a,
    output logic [0:DATA_W-1] op_b,
    output logic [0:DATA_W-1] store_data,
    output logic [0:4]        dest_reg,
    output logic [0:5]        opcode
);

    // One stored entry: op_a, op_b, store_data, dest_reg, opcode
    localparam int ENTRY_W = 3 * DATA_W + 11;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        SKID
    } stateT;

    stateT              state;
    logic [0:ENTRY_W-1] mainEntry;
    logic [0:ENTRY_W-1] skidEntry;
    logic [0:ENTRY_W-1] newEntry;
    logic [0:DATA_W-1]  opBNext;
    logic [0:4]         destNext;
    logic               accept;
    logic               emit;
    logic               unusedRsField;

    // The rs field is already consumed by the register file upstream;
    // only its read value travels through this stage.
    assign unusedRsField = &{1'b0, instr[6:10]};

    // Resolve operand B before storage so the buffer never has to keep
    // the raw immediate or the select code around.
    always_comb begin
        opBNext = '0;
        case (b_sel)
            2'b00:   opBNext = rt_data;
            2'b01:   opBNext = {{16{instr[16]}}, instr[16:31]};
            2'b10:   opBNext = {16'h0000, instr[16:31]};
            2'b11:   opBNext = {instr[16:31], 16'h0000};
            default: opBNext = '0;
        endcase
    end

    // Immediate forms write rt; the register form writes rd.
    assign destNext = (b_sel == 2'b00) ? instr[16:20] : instr[11:15];

    assign newEntry = {rs_data, opBNext, rt_data, destNext, instr[0:5]};

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    // Outputs are plain slices of the main entry register, so nothing on
    // the input side reaches them without passing through a flop.
    assign op_a       = mainEntry[0:DATA_W-1];
    assign op_b       = mainEntry[DATA_W:2*DATA_W-1];
    assign store_data = mainEntry[2*DATA_W:3*DATA_W-1];
    assign dest_reg   = mainEntry[3*DATA_W:3*DATA_W+4];
    assign opcode     = mainEntry[3*DATA_W+5:3*DATA_W+10];

    // Skid buffer control. in_ready and out_valid are registered alongside
    // the state so both handshake outputs come straight from flops. Flush
    // only drops the entries logically; reset also clears the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            mainEntry <= '0;
            skidEntry <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainEntry <= newEntry;
                        out_valid <= 1'b1;
                        state     <= FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        mainEntry <= newEntry;
                    end else if (accept) begin
                        skidEntry <= newEntry;
                        in_ready  <= 1'b0;
                        state     <= SKID;
                    end else if (emit) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (emit) begin
                        mainEntry <= skidEntry;
                        in_ready  <= 1'b1;
                        state     <= FULL;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_operand_latch.sv
// tb_id_ex_operand_latch
//
// Directed bench for id_ex_operand_latch. Inputs are driven 1 ns after a
// rising edge and outputs are checked at that same point, well away from
// the next active edge. Expected values are written out by hand.

module tb_id_ex_operand_latch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:31] instr;
    logic [0:31] rs_data;
    logic [0:31] rt_data;
    logic [0:1]  b_sel;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] op_a;
    logic [0:31] op_b;
    logic [0:31] store_data;
    logic [0:4]  dest_reg;
    logic [0:5]  opcode;

    int vectorCount = 0;
    int missCount   = 0;
    int emitCount   = 0;

    id_ex_operand_latch #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .b_sel      (b_sel),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .store_data (store_data),
        .dest_reg   (dest_reg),
        .opcode     (opcode)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Count handshakes that will complete on the coming rising edge
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) emitCount++;
    end

    // Hard stop in case something keeps the sequence from finishing
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [0:31] mkInstr(input logic [0:5] op, input logic [0:4] rs,
                                            input logic [0:4] rt, input logic [0:15] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [0:31] ins,
                                 input logic [0:31] rsVal, input logic [0:31] rtVal,
                                 input logic [0:1] sel);
        in_valid = valid;
        instr    = ins;
        rs_data  = rsVal;
        rt_data  = rtVal;
        b_sel    = sel;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] got,
                               input logic [127:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkHead(input string tag, input logic [0:31] expA,
                             input logic [0:31] expB, input logic [0:31] expStore,
                             input logic [0:4] expDest, input logic [0:5] expOp);
        checkOutput({tag, ".out_valid"}, out_valid, 1'b1);
        checkOutput({tag, ".op_a"}, op_a, expA);
        checkOutput({tag, ".op_b"}, op_b, expB);
        checkOutput({tag, ".store_data"}, store_data, expStore);
        checkOutput({tag, ".dest_reg"}, dest_reg, expDest);
        checkOutput({tag, ".opcode"}, opcode, expOp);
    endtask

    logic [0:1]  selTable  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [0:31] opBTable  [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hCAFE0003};
    logic [0:4]  destTable [4] = '{5'd2, 5'd2, 5'd2, 5'd16};

    initial begin
        int emitsBefore;
        logic [0:31] immInstr;

        // Reset held two cycles with a valid input present
        rst       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b1, mkInstr(6'h3F, 5'd7, 5'd7, 16'h1234), 32'h12345678,
                      32'h9ABCDEF0, 2'b01);
        for (int c = 0; c < 2; c++) begin
            tick();
            checkOutput("reset.out_valid", out_valid, 1'b0);
            checkOutput("reset.in_ready", in_ready, 1'b1);
            checkOutput("reset.data", {op_a, op_b, store_data, dest_reg, opcode}, 107'd0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        tick();
        checkOutput("postReset.out_valid", out_valid, 1'b0);

        // Immediate forms back to back, each visible one cycle after accept
        immInstr = mkInstr(6'h23, 5'd1, 5'd2, 16'h8001);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, immInstr, 32'h11110000 + k, 32'hCAFE0000 + k, selTable[k]);
            tick();
            checkHead("imm", 32'h11110000 + k, opBTable[k], 32'hCAFE0000 + k,
                      destTable[k], 6'h23);
            checkOutput("imm.in_ready", in_ready, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        tick();
        checkOutput("immDrain.out_valid", out_valid, 1'b0);

        // Eight back-to-back accepts with execute always ready
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, mkInstr(6'(i + 1), 5'd0, 5'd3, 16'h0000),
                          32'h50000000 + i, 32'hA0000000 + i, 2'b00);
            tick();
            checkHead("stream", 32'h50000000 + i, 32'hA0000000 + i, 32'hA0000000 + i,
                      5'd0, 6'(i + 1));
            checkOutput("stream.in_ready", in_ready, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        tick();
        checkOutput("streamDrain.out_valid", out_valid, 1'b0);

        // Back-pressure: A fills main, B fills skid, C is refused
        out_ready = 1'b0;
        applyStimulus(1'b1, mkInstr(6'h0A, 5'd0, 5'd4, 16'h0001), 32'hAAAA0001, 32'h0, 2'b00);
        tick();
        checkOutput("bpA.op_a", op_a, 32'hAAAA0001);
        checkOutput("bpA.in_ready", in_ready, 1'b1);
        applyStimulus(1'b1, mkInstr(6'h0B, 5'd0, 5'd4, 16'h0001), 32'hBBBB0002, 32'h0, 2'b00);
        tick();
        checkOutput("bpB.op_a", op_a, 32'hAAAA0001);
        checkOutput("bpB.in_ready", in_ready, 1'b0);
        applyStimulus(1'b1, mkInstr(6'h0C, 5'd0, 5'd4, 16'h0001), 32'hCCCC0003, 32'h0, 2'b00);
        tick();
        checkOutput("bpC.op_a", op_a, 32'hAAAA0001);
        checkOutput("bpC.opcode", opcode, 6'h0A);
        checkOutput("bpC.in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        tick();
        checkOutput("bpDrain1.op_a", op_a, 32'hBBBB0002);
        checkOutput("bpDrain1.in_ready", in_ready, 1'b1);
        tick();
        checkOutput("bpDrain2.op_a", op_a, 32'hCCCC0003);
        checkOutput("bpDrain2.opcode", opcode, 6'h0C);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        tick();
        checkOutput("bpDrain3.out_valid", out_valid, 1'b0);

        // Flush while in SKID with another entry offered
        out_ready = 1'b0;
        applyStimulus(1'b1, mkInstr(6'h0D, 5'd0, 5'd5, 16'h0000), 32'hDDDD0004, 32'h0, 2'b00);
        tick();
        applyStimulus(1'b1, mkInstr(6'h0E, 5'd0, 5'd5, 16'h0000), 32'hEEEE0005, 32'h0, 2'b00);
        tick();
        checkOutput("preFlush.in_ready", in_ready, 1'b0);
        emitsBefore = emitCount;
        flush = 1'b1;
        applyStimulus(1'b1, mkInstr(6'h0F, 5'd0, 5'd5, 16'h0000), 32'hFFFF0006, 32'h0, 2'b00);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        checkOutput("flush.out_valid", out_valid, 1'b0);
        checkOutput("flush.in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        checkOutput("flushHold.out_valid", out_valid, 1'b0);
        checkOutput("flush.emits", emitCount, emitsBefore);

        // Reset mid-stream clears data; first accept right after release
        applyStimulus(1'b1, mkInstr(6'h11, 5'd0, 5'd6, 16'h0000), 32'h77770007, 32'h0, 2'b00);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midReset.op_a", op_a, 32'h0);
        checkOutput("midReset.out_valid", out_valid, 1'b0);
        applyStimulus(1'b1, mkInstr(6'h12, 5'd0, 5'd6, 16'h0000), 32'h88880008, 32'h1, 2'b10);
        tick();
        checkHead("afterReset", 32'h88880008, 32'h00000000, 32'h1, 5'd6, 6'h12);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 2'b00);
        tick();
        checkOutput("final.out_valid", out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
